// File: rtl/accel_sample_formatter.sv
// accel_sample_formatter
//
// Assembles little-endian 16-bit accelerometer samples from a byte stream
// (SPI read path) and presents one formatted word per axis on a
// valid/ready output port.
//
// Frame format: the first byte carries in_sof and is the low byte of axis 0.
// Each axis is a low byte L followed by a high byte H. The word is
// raw = {H,L}. The output keeps the RES_BITS most significant bits of raw,
// right-justified in an OUT_W word.
//
// Configuration macro: ACCEL_FMT_SIGN_EXT_EN
//   defined   : out_data bits above RES_BITS copy raw[15] (signed sample)
//   undefined : out_data bits above RES_BITS are zero (unsigned fill)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    raw byte
//   in_valid   in_data valid
//   in_sof     first byte of a frame (qualified by in_valid)
//   in_ready   byte accepted when in_valid && in_ready
//   out_data   formatted sample
//   out_axis   0-based axis index of out_data
//   out_last   out_data is the last axis of its frame
//   out_valid  output word valid
//   out_ready  downstream accepts the word
//   frame_err  one-cycle pulse when a frame is resynchronised mid-sample
module accel_sample_formatter #(
  parameter int N_AXES   = 3,
  parameter int RES_BITS = 10,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_axis,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    LOW,
    HIGH
  } state_t;

  localparam logic [1:0] AXIS_LAST = 2'(N_AXES - 1);

  state_t     state, state_nxt;
  logic [7:0] low_byte, low_byte_nxt;
  logic [1:0] axis, axis_nxt;
  logic       load;
  logic       err_nxt;
  logic       in_xfer;
  logic       out_xfer;

  // Keep the top RES_BITS of the raw word and widen to OUT_W.
  function automatic logic [OUT_W-1:0] fmt_sample(input logic [15:0] raw);
    logic signed [RES_BITS-1:0] smp;
    smp = signed'(RES_BITS'(raw >> (16 - RES_BITS)));
`ifdef ACCEL_FMT_SIGN_EXT_EN
    fmt_sample = OUT_W'(smp);
`else
    fmt_sample = OUT_W'($unsigned(smp));
`endif
  endfunction

  // Only the HIGH byte can be blocked: it is the one that overwrites the
  // output register, so it waits until the current word is gone or leaving.
  assign in_ready = (state != HIGH) || !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    low_byte_nxt = low_byte;
    axis_nxt     = axis;
    load         = 1'b0;
    err_nxt      = 1'b0;
    if (in_xfer) begin
      if (in_sof) begin
        // A start of frame always restarts at axis 0. It is an error unless
        // it arrives exactly on a frame boundary.
        state_nxt    = HIGH;
        axis_nxt     = 2'd0;
        low_byte_nxt = in_data;
        err_nxt      = (state == HIGH) || ((state == LOW) && (axis != 2'd0));
      end else begin
        case (state)
          WAIT_SOF: ;
          LOW: begin
            low_byte_nxt = in_data;
            state_nxt    = HIGH;
          end
          HIGH: begin
            load = 1'b1;
            if (axis == AXIS_LAST) begin
              axis_nxt  = 2'd0;
              state_nxt = WAIT_SOF;
            end else begin
              axis_nxt  = axis + 2'd1;
              state_nxt = LOW;
            end
          end
          default: state_nxt = WAIT_SOF;
        endcase
      end
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      axis      <= 2'd0;
      low_byte  <= 8'd0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      axis      <= axis_nxt;
      low_byte  <= low_byte_nxt;
      frame_err <= err_nxt;
      // A load in the same cycle as a transfer replaces the word directly.
      if (load) begin
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_axis <= 2'd0;
      out_last <= 1'b0;
    end else if (load) begin
      out_data <= fmt_sample({in_data, low_byte});
      out_axis <= axis;
      out_last <= (axis == AXIS_LAST);
    end
  end

endmodule

// File: doc/accel_sample_formatter.md
ACCEL_SAMPLE_FORMATTER -- requirements
Module: accel_sample_formatter

Interface
REQ-001 Parameter N_AXES, default 3, number of axes per frame; legal range 1-4.
REQ-002 Parameter RES_BITS, default 10, significant sample bits; legal range 8-16.
REQ-003 Parameter OUT_W, default 16, output word width; legal range RES_BITS to 32.
REQ-004 Port clk, input, 1, the single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 Port in_data, input, 8, raw byte from the SPI read path.
REQ-007 Port in_valid, input, 1, in_data is valid.
REQ-008 Port in_sof, input, 1, qualified by in_valid; marks the first byte of a frame.
REQ-009 Port in_ready, output, 1, the block accepts a byte this cycle.
REQ-010 Port out_data, output, OUT_W, formatted sample.
REQ-011 Port out_axis, output, 2, axis index of out_data, 0-based.
REQ-012 Port out_last, output, 1, out_data is the last axis of its frame.
REQ-013 Port out_valid, output, 1, the output word is valid.
REQ-014 Port out_ready, input, 1, downstream accepts the output word.
REQ-015 Port frame_err, output, 1, one-cycle pulse on a frame resynchronisation.

Function
REQ-016 A byte SHALL transfer when in_valid and in_ready are both 1; an output word SHALL transfer when out_valid and out_ready are both 1.
REQ-017 The FSM SHALL have states WAIT_SOF, LOW, HIGH; after reset it SHALL be in WAIT_SOF.
REQ-018 WAIT_SOF SHALL drop bytes without in_sof, and SHALL move to HIGH with axis=0 on a byte with in_sof, storing it as the low byte L.
REQ-019 LOW SHALL store an accepted byte as L and move to HIGH.
REQ-020 HIGH SHALL, on an accepted byte H, form raw={H,L} and load the output register in the same edge. The output is raw[15:16-RES_BITS], sign-extended or zero-filled to OUT_W per REQ-031.
REQ-021 On the HIGH transfer, axis SHALL increment and the FSM SHALL go to LOW. If axis==N_AXES-1, out_last SHALL be 1, axis SHALL wrap to 0, and the FSM SHALL go to WAIT_SOF.
REQ-022 Latency: out_valid SHALL assert on the first rising edge after the HIGH byte transfer.
REQ-023 in_ready SHALL be 1 in WAIT_SOF and LOW; in HIGH it SHALL equal (!out_valid || out_ready).
REQ-024 While out_valid=1 and out_ready=0, out_data, out_axis and out_last SHALL hold stable.
REQ-025 If an output transfer and a new HIGH load occur in the same cycle, the new word SHALL replace the old one with no bubble, so throughput is one word per two bytes.
REQ-026 A byte with in_sof accepted in LOW or HIGH SHALL discard the partial sample, pulse frame_err, set axis=0, store the byte as L, and go to HIGH.
REQ-027 An in_sof byte accepted in LOW with axis=0 (frame boundary) SHALL NOT pulse frame_err.
REQ-028 out_valid SHALL clear on an output transfer when no new load occurs in the same cycle.

Reset
REQ-029 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_axis=0, out_last=0, frame_err=0, axis=0, L=0, FSM=WAIT_SOF.
REQ-030 A reset arriving mid-frame or mid-handshake SHALL discard all partial data; after release, the first word SHALL come only from a new in_sof frame.

Configuration
REQ-031 Macro ACCEL_FMT_SIGN_EXT_EN: when defined, out_data[OUT_W-1:RES_BITS] SHALL replicate raw[15]. When undefined, these bits SHALL be 0, giving unsigned zero-fill.

Verification
REQ-032 Defaults with sign extension; bytes L=0xC0 (sof), H=0x7F, then 0x40,0x80, then 0x00,0x00 -> out_data 0x01FF axis0, 0xFE01 axis1, 0x0000 axis2 with out_last=1.
REQ-033 Same stimulus with the macro undefined -> axis1 out_data=0x0201.
REQ-034 out_ready held 0 for 5 cycles after the axis0 word -> word stable; in_ready=0 in HIGH; no byte lost once out_ready returns to 1.
REQ-035 in_sof byte injected after axis1 L -> frame_err pulses one cycle; partial sample dropped; next output is axis0 from the new frame.
REQ-036 rst_n pulsed low between the L and H bytes -> all outputs 0 immediately; subsequent non-sof bytes produce no output.
REQ-037 Continuous in_valid with out_ready=1 -> one word every 2 cycles; axis sequence 0,1,2,0; out_last only on axis 2.
